// File: rtl/genesis_bus_pkg.sv
// Shared types, constants and decode helper for the Genesis bus arbiter.
package genesis_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_ACC,
    S_RAM_DATA,
    S_VDP_WAIT,
    S_ACK,
    S_RELEASE
  } bus_state_t;

  localparam logic [23:0] VDP_BASE_DEFAULT = 24'hC00000;
  localparam int unsigned VDP_WIN_SIZE     = 32;

  function automatic logic is_vdp(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base) && ((addr - base) < VDP_WIN_SIZE);
  endfunction

endpackage

// File: rtl/genesis_bus_arbiter_rr.sv
// Request arbiter: round-robin from last_grant+1, or fixed lowest-index priority.
module bus_rr_arbiter #(
  parameter int unsigned N       = 2,
  parameter bit          RR_MODE = 1'b1,
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             update,
  output logic             any,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last_grant;

  always_comb begin
    int unsigned c;
    logic [IDX_W-1:0] ci;
    any     = 1'b0;
    gnt_idx = '0;
    c       = 0;
    ci      = '0;
    if (RR_MODE) begin
      for (int unsigned i = 1; i <= N; i++) begin
        c = 32'(last_grant) + i;
        if (c >= N) c = c - N;
        ci = IDX_W'(c);
        if (!any && req[ci]) begin
          any     = 1'b1;
          gnt_idx = ci;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        ci = IDX_W'(i);
        if (!any && req[ci]) begin
          any     = 1'b1;
          gnt_idx = ci;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                last_grant <= IDX_W'(N - 1);
    else if (update && any) last_grant <= gnt_idx;
  end

endmodule

// File: rtl/genesis_bus_arbiter.sv
// Multi-master arbiter and RAM/VDP target decoder with DTACK-style acknowledges.
module genesis_bus_arbiter
  import genesis_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RAM_ADDR_W  = 12,
  parameter logic [31:0] VDP_BASE    = 32'(VDP_BASE_DEFAULT),
  parameter int unsigned ACK_HOLD    = 2,
  parameter int unsigned VDP_TIMEOUT = 255,
  parameter bit          RR_MODE     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*2-1:0]      m_be,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [RAM_ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic                          vdp_sel,
  output logic                          vdp_rnw,
  output logic [4:0]                    vdp_a,
  output logic                          vdp_uds_n,
  output logic                          vdp_lds_n,
  output logic [DATA_W-1:0]             vdp_di,
  input  logic [DATA_W-1:0]             vdp_do,
  input  logic                          vdp_dtack_n,
  input  logic                          vdp_vbus_sel,
  output logic                          bus_busy
);

  localparam int unsigned IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned TMO_W  = (VDP_TIMEOUT > 0) ? $clog2(VDP_TIMEOUT + 1) : 1;
  localparam int unsigned HOLD_W = (ACK_HOLD > 0) ? $clog2(ACK_HOLD + 1) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((VDP_TIMEOUT > 0) ? VDP_TIMEOUT - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACK_HOLD);

  bus_state_t             state, state_nxt;
  logic [IDX_W-1:0]       g, g_nxt, win;
  logic                   lat_we, lat_we_nxt;
  logic [TMO_W-1:0]       tmo, tmo_nxt;
  logic [HOLD_W-1:0]      hold, hold_nxt;
  logic                   req_any, grant;
  logic [NUM_MASTERS-1:0] g_onehot;

  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [1:0]             sel_be;

  logic [NUM_MASTERS-1:0] m_ack_nxt, m_err_nxt;
  logic [DATA_W-1:0]      m_rdata_nxt, ram_wdata_nxt, vdp_di_nxt;
  logic                   ram_en_nxt, ram_we_nxt;
  logic [RAM_ADDR_W-1:0]  ram_addr_nxt;
  logic                   vdp_sel_nxt, vdp_rnw_nxt, vdp_uds_n_nxt, vdp_lds_n_nxt;
  logic [4:0]             vdp_a_nxt;

  assign grant    = (state == S_IDLE) && !vdp_vbus_sel && req_any;
  assign g_onehot = NUM_MASTERS'(1) << g;
  assign bus_busy = (state != S_IDLE);

  bus_rr_arbiter #(
    .N       (NUM_MASTERS),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (m_req),
    .update  (grant),
    .any     (req_any),
    .gnt_idx (win)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (win == IDX_W'(i)) begin
        sel_we    = m_we[i];
        sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[i*DATA_W +: DATA_W];
        sel_be    = m_be[i*2 +: 2];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    g_nxt         = g;
    lat_we_nxt    = lat_we;
    tmo_nxt       = tmo;
    hold_nxt      = hold;
    m_ack_nxt     = m_ack;
    m_err_nxt     = m_err;
    m_rdata_nxt   = m_rdata;
    ram_en_nxt    = ram_en;
    ram_we_nxt    = ram_we;
    ram_addr_nxt  = ram_addr;
    ram_wdata_nxt = ram_wdata;
    vdp_sel_nxt   = vdp_sel;
    vdp_rnw_nxt   = vdp_rnw;
    vdp_a_nxt     = vdp_a;
    vdp_uds_n_nxt = vdp_uds_n;
    vdp_lds_n_nxt = vdp_lds_n;
    vdp_di_nxt    = vdp_di;
    unique case (state)
      S_IDLE: begin
        if (grant) begin
          g_nxt      = win;
          lat_we_nxt = sel_we;
          tmo_nxt    = '0;
          hold_nxt   = '0;
          if (is_vdp(32'(sel_addr), VDP_BASE)) begin
            vdp_sel_nxt   = 1'b1;
            vdp_rnw_nxt   = ~sel_we;
            vdp_a_nxt     = sel_addr[4:0];
            vdp_uds_n_nxt = ~sel_be[1];
            vdp_lds_n_nxt = ~sel_be[0];
            vdp_di_nxt    = sel_wdata;
            state_nxt     = S_VDP_WAIT;
          end else begin
            ram_en_nxt    = 1'b1;
            ram_we_nxt    = sel_we;
            ram_addr_nxt  = sel_addr[RAM_ADDR_W:1];
            ram_wdata_nxt = sel_wdata;
            state_nxt     = S_RAM_ACC;
          end
        end
      end
      S_RAM_ACC: begin
        ram_en_nxt = 1'b0;
        ram_we_nxt = 1'b0;
        if (lat_we) begin
          m_ack_nxt = g_onehot;
          state_nxt = S_ACK;
        end else begin
          state_nxt = S_RAM_DATA;
        end
      end
      S_RAM_DATA: begin
        m_rdata_nxt = ram_rdata;
        m_ack_nxt   = g_onehot;
        state_nxt   = S_ACK;
      end
      S_VDP_WAIT: begin
        if (!vdp_dtack_n) begin
          vdp_sel_nxt = 1'b0;
          if (!lat_we) m_rdata_nxt = vdp_do;
          m_ack_nxt   = g_onehot;
          state_nxt   = S_ACK;
        end else if (tmo == TMO_LAST) begin
          vdp_sel_nxt = 1'b0;
          m_rdata_nxt = '1;
          m_ack_nxt   = g_onehot;
          m_err_nxt   = g_onehot;
          state_nxt   = S_ACK;
        end else begin
          tmo_nxt = tmo + 1'b1;
        end
      end
      S_ACK: begin
        if (hold == HOLD_LAST) begin
          m_ack_nxt = '0;
          m_err_nxt = '0;
          state_nxt = S_RELEASE;
        end else begin
          hold_nxt = hold + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!m_req[g]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      g         <= '0;
      lat_we    <= 1'b0;
      tmo       <= '0;
      hold      <= '0;
      m_ack     <= '0;
      m_err     <= '0;
      m_rdata   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      vdp_sel   <= 1'b0;
      vdp_rnw   <= 1'b1;
      vdp_a     <= '0;
      vdp_uds_n <= 1'b1;
      vdp_lds_n <= 1'b1;
      vdp_di    <= '0;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      lat_we    <= lat_we_nxt;
      tmo       <= tmo_nxt;
      hold      <= hold_nxt;
      m_ack     <= m_ack_nxt;
      m_err     <= m_err_nxt;
      m_rdata   <= m_rdata_nxt;
      ram_en    <= ram_en_nxt;
      ram_we    <= ram_we_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
      vdp_sel   <= vdp_sel_nxt;
      vdp_rnw   <= vdp_rnw_nxt;
      vdp_a     <= vdp_a_nxt;
      vdp_uds_n <= vdp_uds_n_nxt;
      vdp_lds_n <= vdp_lds_n_nxt;
      vdp_di    <= vdp_di_nxt;
    end
  end

endmodule
